// File: rtl/quick_spi_sequencer_if.sv
// Command, response and quick_spi master signals of the SPI command sequencer.
// The sequencer connects through the slave modport; its environment uses master.
interface quick_spi_sequencer_if #(
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int NUMBER_OF_SLAVES    = 2
);
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [NUMBER_OF_SLAVES-1:0]    cmd_slave;
  logic                           cmd_operation;
  logic [OUTGOING_DATA_WIDTH-1:0] cmd_data;

  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [INCOMING_DATA_WIDTH-1:0] rsp_data;
  logic [NUMBER_OF_SLAVES-1:0]    rsp_slave;
  logic                           rsp_error;

  logic                           spi_enable;
  logic                           spi_start;
  logic [NUMBER_OF_SLAVES-1:0]    spi_slave;
  logic                           spi_operation;
  logic [OUTGOING_DATA_WIDTH-1:0] spi_outgoing_data;
  logic                           spi_end_of_transaction;
  logic [INCOMING_DATA_WIDTH-1:0] spi_incoming_data;

  modport slave (
    input  cmd_valid, cmd_slave, cmd_operation, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_slave, rsp_error,
    input  rsp_ready,
    output spi_enable, spi_start, spi_slave, spi_operation, spi_outgoing_data,
    input  spi_end_of_transaction, spi_incoming_data
  );

  modport master (
    output cmd_valid, cmd_slave, cmd_operation, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_slave, rsp_error,
    output rsp_ready,
    input  spi_enable, spi_start, spi_slave, spi_operation, spi_outgoing_data,
    output spi_end_of_transaction, spi_incoming_data
  );
endinterface

// File: rtl/quick_spi_sequencer.sv
// Queues SPI commands and issues them one at a time to the quick_spi master,
// enforcing a chip-select gap, returning read data and aborting hung transfers.
module quick_spi_sequencer #(
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int NUMBER_OF_SLAVES    = 2,
  parameter int CMD_FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES          = 2,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              enable_i,
  quick_spi_sequencer_if.slave              bus,
  output logic                              timeout_pulse_o,
  output logic                              busy_o,
  output logic [$clog2(CMD_FIFO_DEPTH):0]   fifo_level_o
);

  localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(CMD_FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef struct packed {
    logic [NUMBER_OF_SLAVES-1:0]    slave;
    logic                           operation;
    logic [OUTGOING_DATA_WIDTH-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_EOT,
    GAP
  } state_e;

  cmd_t                           fifo_mem_q [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]               level_q, level_d;
  logic                           push, pop, launch;
  cmd_t                           head, incoming_cmd;

  state_e                         state_q, state_d;
  logic [TO_W-1:0]                to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]               gap_cnt_q, gap_cnt_d;
  logic                           timeout_q, timeout_d;
  logic                           spi_enable_q;
  logic [NUMBER_OF_SLAVES-1:0]    spi_slave_q, spi_slave_d;
  logic                           spi_op_q, spi_op_d;
  logic [OUTGOING_DATA_WIDTH-1:0] spi_data_q, spi_data_d;
  logic                           rsp_valid_q, rsp_valid_d;
  logic [INCOMING_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [NUMBER_OF_SLAVES-1:0]    rsp_slave_q, rsp_slave_d;
  logic                           rsp_error_q, rsp_error_d;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign push         = bus.cmd_valid && (level_q != LVL_FULL);
  assign head         = fifo_mem_q[rd_ptr_q];
  assign incoming_cmd = '{slave: bus.cmd_slave, operation: bus.cmd_operation, data: bus.cmd_data};

  // A READ may only go out once the response register is free, so a new
  // response can never overwrite one that has not been consumed.
  assign launch = (state_q == IDLE) && enable_i && (level_q != '0) &&
                  !((head.operation == 1'b0) && rsp_valid_q);
  assign pop    = launch;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= incoming_cmd;
    end
  end

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    timeout_d   = 1'b0;
    spi_slave_d = spi_slave_q;
    spi_op_d    = spi_op_q;
    spi_data_d  = spi_data_q;
    rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_slave_d = rsp_slave_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (launch) begin
          spi_slave_d = head.slave;
          spi_op_d    = head.operation;
          spi_data_d  = head.data;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        to_cnt_d = '0;
        state_d  = WAIT_EOT;
      end
      WAIT_EOT: begin
        // End of transaction wins over a timeout landing in the same cycle.
        if (bus.spi_end_of_transaction) begin
          if (!spi_op_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.spi_incoming_data;
            rsp_slave_d = spi_slave_q;
            rsp_error_d = 1'b0;
          end
          gap_cnt_d = '0;
          state_d   = GAP;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          if (!spi_op_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_slave_d = spi_slave_q;
            rsp_error_d = 1'b1;
          end
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= IDLE;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      timeout_q    <= 1'b0;
      spi_enable_q <= 1'b0;
      spi_slave_q  <= '0;
      spi_op_q     <= 1'b0;
      spi_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_slave_q  <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      timeout_q    <= timeout_d;
      spi_enable_q <= enable_i;
      spi_slave_q  <= spi_slave_d;
      spi_op_q     <= spi_op_d;
      spi_data_q   <= spi_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_slave_q  <= rsp_slave_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  assign bus.cmd_ready         = (level_q != LVL_FULL);
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_data          = rsp_data_q;
  assign bus.rsp_slave         = rsp_slave_q;
  assign bus.rsp_error         = rsp_error_q;
  assign bus.spi_enable        = spi_enable_q;
  assign bus.spi_start         = (state_q == ISSUE);
  assign bus.spi_slave         = spi_slave_q;
  assign bus.spi_operation     = spi_op_q;
  assign bus.spi_outgoing_data = spi_data_q;
  assign timeout_pulse_o       = timeout_q;
  assign busy_o                = (state_q != IDLE);
  assign fifo_level_o          = level_q;

endmodule
